// File: rtl/receiver.sv
// UART document receiver: 8N1 serial bytes (8E1 with RX_PARITY_EN defined)
// are written into consecutive document cells. Bytes 0x0A/0x0D terminate the
// document with a done pulse and rewind the address. Rejected frames
// (framing error, or parity error when RX_PARITY_EN is defined) bump a
// saturating error counter.
module receiver #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600,
   parameter int DOC_SIZE = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RsRx,
   output logic       write_en,
   output logic [8:0] write_addr,
   output logic [7:0] write_data,
   output logic       busy,
   output logic       done,
   output logic [3:0] err_count
);

   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = $clog2(DIV + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [8:0]       ADDR_MAX = 9'(DOC_SIZE);

`ifdef RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WRITE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE} state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [8:0]       addr_q, addr_d;
   logic [3:0]       err_q, err_d;
   logic             sync1_q, sync2_q, prev_q;
   logic             term;
   logic [3:0]       err_inc;

   assign term     = (wdata_q == 8'h0A) || (wdata_q == 8'h0D);
   assign err_inc  = (err_q == 4'hF) ? err_q : err_q + 4'd1;

   assign busy       = (state_q != IDLE);
   assign write_en   = (state_q == WRITE) && !term && (addr_q < ADDR_MAX);
   assign done       = (state_q == WRITE) && term;
   assign write_addr = addr_q;
   assign write_data = wdata_q;
   assign err_count  = err_q;

   // Synchronize the serial line and keep its previous value for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= RsRx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Frame state and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: bit timing, sampling, frame checks and document writes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (prev_q && !sync2_q) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               bit_d = '0;
               // A line already back high at mid start bit is a glitch, not an error.
               state_d = sync2_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
`ifdef RX_PARITY_EN
               if (bit_q == 3'd7) state_d = PARITY;
`else
               if (bit_q == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               // Even parity: data bits plus parity bit must XOR to zero.
               if (^{shift_q, sync2_q}) begin
                  err_d   = err_inc;
                  state_d = IDLE;
               end else begin
                  state_d = STOP;
               end
            end
         end
`endif
         STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (sync2_q) begin
                  wdata_d = shift_q;
                  state_d = WRITE;
               end else begin
                  err_d   = err_inc;
                  state_d = IDLE;
               end
            end
         end
         WRITE: begin
            cnt_d   = '0;
            state_d = IDLE;
            if (term) addr_d = '0;
            else if (addr_q < ADDR_MAX) addr_d = addr_q + 9'd1;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter CLK_FREQ, default 100000000: clk frequency in Hz.
REQ-002 Parameter BAUD, default 9600: serial bit rate; DIV = CLK_FREQ/BAUD clocks per bit (integer division, DIV >= 4).
REQ-003 Parameter DOC_SIZE, default 300: number of writable document cells, addresses 0..DOC_SIZE-1.
REQ-004 clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 RsRx  input  1  UART serial line, 8 data bits, LSB first, 1 stop bit, idle high, asynchronous to clk.
REQ-007 write_en  output  1  one-cycle document write strobe.
REQ-008 write_addr  output  9  document cell address for the write.
REQ-009 write_data  output  8  received byte for the write.
REQ-010 busy  output  1  high from start-bit detection until the frame completes or is rejected.
REQ-011 done  output  1  one-cycle pulse when a terminator byte is received.
REQ-012 err_count  output  4  count of rejected frames, saturating at 15.

Function
REQ-013 RsRx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 FSM states: IDLE, START, DATA, PARITY (only with RX_PARITY_EN), STOP, WRITE.
REQ-015 IDLE: synchronized line 1->0 edge -> START, busy=1, bit timer cleared.
REQ-016 START: after DIV/2 clocks, sample; 0 -> DATA; 1 -> glitch, return to IDLE, err_count unchanged.
REQ-017 DATA: sample every DIV clocks, 8 samples shifted in LSB first, then -> PARITY or STOP.
REQ-018 STOP: sample after DIV clocks; 1 -> WRITE; 0 -> framing error: byte discarded, err_count+1 (saturating), -> IDLE.
REQ-019 WRITE (one cycle), byte not a terminator: if write_addr < DOC_SIZE, assert write_en with write_data = byte, then increment write_addr; if write_addr = DOC_SIZE, discard the byte, no write_en, address held.
REQ-020 Terminator bytes 0x0A and 0x0D: no write_en; done=1 for one cycle; write_addr returns to 0.
REQ-021 busy SHALL drop in the cycle after WRITE or rejection; a new start edge is accepted from the next IDLE cycle (back-to-back frames with zero idle time SHALL be received).
REQ-022 write_addr, write_data SHALL be stable during the write_en cycle; write_data holds the last received byte otherwise.
REQ-023 write_en and done SHALL never be high in the same cycle.

Reset
REQ-024 rst=0 SHALL asynchronously force: state IDLE, write_en=0, write_addr=0, write_data=0, busy=0, done=0, err_count=0, synchronizer flops=1.
REQ-025 rst asserted mid-frame SHALL abort the frame with no write; after release, reception resumes at the next start edge.

Configuration
REQ-026 Macro RX_PARITY_EN defined: frame carries an even-parity bit after data; PARITY state samples it after DIV clocks; mismatch = rejection (discard, err_count+1, -> IDLE).
REQ-027 Macro RX_PARITY_EN undefined: no PARITY state; frame is 8N1; the bit after data is treated as stop.

Verification
REQ-028 CLK_FREQ=1600000, BAUD=100000 (DIV=16): send 0x41,0x42 -> write_en at addr 0 data 0x41, addr 1 data 0x42; err_count=0.
REQ-029 Send 0x48,0x0A -> one write (addr 0, 0x48), then done pulse, write_addr=0, no write for 0x0A.
REQ-030 Frame 0x55 with stop bit driven 0 -> no write_en, err_count=1; next 0x55 frame written at addr 0.
REQ-031 4-clock low glitch on idle RsRx -> no write_en, busy returns 0, err_count unchanged.
REQ-032 DOC_SIZE=2: send 0x31,0x32,0x33 -> writes at addr 0,1 only; third byte discarded; then 0x0D -> done, write_addr=0.
REQ-033 rst=0 at data bit 4 of a frame -> all outputs reset immediately; following full frame 0x7E written at addr 0; with RX_PARITY_EN, 0x7E with odd parity bit -> err_count+1, no write.
